// File: rtl/wb_regfile_if.sv
// W-stage bundle between the MEM/WB register and the writeback/register-file block,
// including the decode read ports and the forwarded result.
interface wb_regfile_if #(
    parameter int XLEN = 32
);
    logic            regwritew;
    logic [1:0]      resultsrcw;
    logic [XLEN-1:0] aluresultw;
    logic [XLEN-1:0] readdataw;
    logic [XLEN-1:0] extimmw;
    logic [XLEN-1:0] pcplus4w;
    logic [4:0]      rdw;
    logic [4:0]      a1d;
    logic [4:0]      a2d;
    logic [XLEN-1:0] rd1d;
    logic [XLEN-1:0] rd2d;
    logic [XLEN-1:0] resultw;

    modport master (
        output regwritew, resultsrcw, aluresultw, readdataw, extimmw, pcplus4w,
        output rdw, a1d, a2d,
        input  rd1d, rd2d, resultw
    );

    modport slave (
        input  regwritew, resultsrcw, aluresultw, readdataw, extimmw, pcplus4w,
        input  rdw, a1d, a2d,
        output rd1d, rd2d, resultw
    );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback stage: result select, 32xXLEN architectural register file with x0 = 0,
// two combinational read ports with optional same-cycle write-through.
module wb_regfile #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);
    logic [XLEN-1:0] regs_q [0:31];
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wr_en;

    always_comb begin
        result = bus.aluresultw;
        unique case (bus.resultsrcw)
            2'b00: result = bus.aluresultw;
            2'b01: result = bus.readdataw;
            2'b10: result = bus.pcplus4w;
            2'b11: result = bus.extimmw;
            default: result = bus.aluresultw;
        endcase
    end

    assign wr_en = bus.regwritew && (bus.rdw != 5'd0);

    // Entry 0 is cleared on reset and never written; reads of x0 are forced to zero anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.rdw] <= result;
        end
    end

    always_comb begin
        rd1 = regs_q[bus.a1d];
        if (bus.a1d == 5'd0) begin
            rd1 = '0;
        end else if (BYPASS && wr_en && (bus.a1d == bus.rdw)) begin
            rd1 = result;
        end
    end

    always_comb begin
        rd2 = regs_q[bus.a2d];
        if (bus.a2d == 5'd0) begin
            rd2 = '0;
        end else if (BYPASS && wr_en && (bus.a2d == bus.rdw)) begin
            rd2 = result;
        end
    end

    assign bus.resultw = result;
    assign bus.rd1d    = rd1;
    assign bus.rd2d    = rd2;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback end of the MEM/WB pipeline register in the 5-stage RV32I core.
- Consumes the registered W-stage signals and selects the writeback result.
- Commits the result into the 32x32 architectural register file and serves the two decode-stage read ports.
- Drives resultw back to the execute-stage forwarding mux.
- Holds all architectural integer state, with x0 hardwired to zero and optional same-cycle write-through bypass.

Parameters:
- XLEN, 32, data width of registers and all data ports.
- BYPASS, 1, 1 = a read of the register being written this cycle returns the write data; 0 = returns the stored (old) value.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- regwritew  input  1  W-stage write enable
- resultsrcw  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 extended immediate
- aluresultw  input  XLEN  ALU result
- readdataw  input  XLEN  load data
- extimmw  input  XLEN  extended immediate (LUI path)
- pcplus4w  input  XLEN  link address (JAL/JALR)
- rdw  input  5  destination register index
- a1d  input  5  decode read port 1 index (rs1)
- a2d  input  5  decode read port 2 index (rs2)
- rd1d  output  XLEN  read port 1 data
- rd2d  output  XLEN  read port 2 data
- resultw  output  XLEN  selected writeback result, to forwarding mux

Behaviour:
- Reset and clocking:
  - One clock domain.
  - Reset is asynchronous and active-high; its polarity and synchronicity are fixed.
  - While rst=1, all 32 registers clear to 0 immediately, independent of clk.
  - Rising-edge updates resume on the first edge after rst deasserts.
- Result mux (combinational, zero latency):
  - resultw = aluresultw / readdataw / pcplus4w / extimmw for resultsrcw = 00 / 01 / 10 / 11.
  - resultw depends only on its inputs and is not affected by reset.
- Write:
  - On a rising edge with rst=0, regwritew=1 and rdw!=0, reg[rdw] <= resultw.
  - rdw=0 never writes; x0 stays 0 permanently.
  - regwritew=0 leaves every register unchanged regardless of the other inputs.
- Read (combinational, zero latency):
  - rdNd = 0 when aNd=0.
  - When BYPASS=1, regwritew=1 and aNd==rdw!=0: rdNd = resultw (write-through, removes the WB->ID hazard).
  - Otherwise rdNd = reg[aNd].
  - The two ports are independent; both may address the same register, and both may bypass in the same cycle.
- Outputs during reset:
  - rd1d/rd2d read 0 for every address, except that the bypass path (BYPASS=1) still returns resultw.
- Reset mid-operation:
  - A write whose edge coincides with rst=1 is discarded.
- Width rules:
  - All data XLEN bits, no extension or truncation inside the block.
  - Indices are 5-bit, so there is no out-of-range case.
- Timing:
  - No stall or flush inputs; the upstream MEM/WB register handles bubbles by presenting regwritew=0.
- Implementation:
  - Flop-based array; no inferred RAM, because of the async clear.

Test Plan:
- Reset: assert rst for 2 cycles then release; read a1d=0..31 sequentially -> rd1d=0 for all.
- Result mux: aluresultw=0x11, readdataw=0x22, pcplus4w=0x33, extimmw=0x44; sweep resultsrcw 00..11 -> resultw=0x11,0x22,0x33,0x44.
- Write/read: regwritew=1, rdw=5, resultsrcw=01, readdataw=0xDEADBEEF, one edge; then regwritew=0, a1d=5, a2d=5 -> rd1d=rd2d=0xDEADBEEF.
- x0 protection: regwritew=1, rdw=0, aluresultw=0xFFFFFFFF, resultsrcw=00, edge; a1d=0 -> rd1d=0.
- Bypass, BYPASS=1: reg7 holds 0x1; same cycle regwritew=1, rdw=7, pcplus4w=0x100, resultsrcw=10, a2d=7 -> rd2d=0x100 before the edge.
  - Same stimulus with BYPASS=0 -> rd2d=0x1 before the edge, 0x100 after it.
- Async reset mid-run: reg3=0x55; raise rst between edges -> rd1d(a1d=3) becomes 0 without a clock edge.
  - Edge with rst=1, regwritew=1, rdw=3, resultw=0x77 -> reg3 stays 0 after release.
